// File: rtl/counter_seq_tx.sv
// Serial run-length transmitter: drives o_dat high for N enable ticks, then low
// for exactly one separator tick, with a valid/ready request handshake.
module counter_seq_tx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_sclr,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_cnt,
  output logic             o_ready,
  output logic             o_dat,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q, done_d;

  // State register; async reset first, then synchronous clear
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else if (i_sclr) begin
      state_q <= IDLE;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; an i_en coinciding with acceptance is not counted as a bit
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          rem_d   = i_cnt;
          state_d = (i_cnt != '0) ? RUN : GAP;
        end
      end
      RUN: begin
        if (i_en) begin
          rem_d = rem_q - WIDTH'(1);
          if (rem_q == WIDTH'(1)) begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (i_en) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // Status lines decode straight from the state register
  assign o_ready = (state_q == IDLE);
  assign o_busy  = (state_q != IDLE);
  assign o_dat   = (state_q == RUN);
  assign o_done  = done_q;

endmodule

// File: tb/tb_counter_seq_tx.sv
// Directed self-checking bench for counter_seq_tx with a behavioural
// consecutive-ones receiver fed by o_dat for the loopback scenario.
module tb_counter_seq_tx;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             i_rst;
  logic             i_sclr;
  logic             i_en;
  logic             i_valid;
  logic [WIDTH-1:0] i_cnt;
  logic             o_ready;
  logic             o_dat;
  logic             o_busy;
  logic             o_done;

  int n_cmp;
  int n_err;

  logic [7:0] rx_cnt;

  counter_seq_tx #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_sclr  (i_sclr),
    .i_en    (i_en),
    .i_valid (i_valid),
    .i_cnt   (i_cnt),
    .o_ready (o_ready),
    .o_dat   (o_dat),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receive-side consecutive-ones counter sampling o_dat on the same i_en
  always @(posedge clk or posedge i_rst) begin
    if (i_rst) rx_cnt <= 8'd0;
    else if (i_sclr) rx_cnt <= 8'd0;
    else if (i_en) rx_cnt <= o_dat ? rx_cnt + 8'd1 : 8'd0;
  end

  // Drive i_en for one cycle, then settle 1 time unit past the edge
  task automatic step(input logic en);
    i_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_sclr = 1'b0; i_en = 1'b0; i_valid = 1'b0; i_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    step(1'b0);
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b want=1", o_ready); end
    n_cmp++; if (o_dat !== 1'b0) begin n_err++; $display("FAIL reset_dat got=%b want=0", o_dat); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", o_done); end
  endtask

  // N=3 with i_en every 4th clock
  task automatic test_run3_slow;
    int hi;
    i_valid = 1'b1; i_cnt = 4'd3;
    step(1'b0);
    i_valid = 1'b0;
    n_cmp++; if (o_dat !== 1'b1) begin n_err++; $display("FAIL run3_latency dat got=%b want=1", o_dat); end
    n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL run3_busy got=%b want=1", o_busy); end
    hi = 0;
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 3; k++) begin
        step(1'b0);
        n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL run3_early_done tick=%0d got=%b want=0", t, o_done); end
      end
      if (o_dat === 1'b1) hi++;
      n_cmp++; if (o_dat !== (t < 3)) begin n_err++; $display("FAIL run3_tick_dat tick=%0d got=%b want=%b", t, o_dat, (t < 3)); end
      step(1'b1);
    end
    n_cmp++; if (hi !== 3) begin n_err++; $display("FAIL run3_high_ticks got=%0d want=3", hi); end
    n_cmp++; if (o_done !== 1'b1) begin n_err++; $display("FAIL run3_done got=%b want=1", o_done); end
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL run3_ready got=%b want=1", o_ready); end
    step(1'b0);
    n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL run3_done_pulse got=%b want=0", o_done); end
  endtask

  // N=0 emits only the separator tick
  task automatic test_zero;
    i_valid = 1'b1; i_cnt = 4'd0;
    step(1'b0);
    i_valid = 1'b0;
    n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL zero_busy got=%b want=1", o_busy); end
    for (int k = 0; k < 2; k++) begin
      step(1'b0);
      n_cmp++; if (o_dat !== 1'b0) begin n_err++; $display("FAIL zero_dat cyc=%0d got=%b want=0", k, o_dat); end
    end
    step(1'b1);
    n_cmp++; if (o_done !== 1'b1) begin n_err++; $display("FAIL zero_done got=%b want=1", o_done); end
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready got=%b want=1", o_ready); end
    step(1'b0);
    n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL zero_done_pulse got=%b want=0", o_done); end
  endtask

  // N=15 with i_en every clock; i_en in the accept cycle must not count
  task automatic test_max;
    int hi;
    i_valid = 1'b1; i_cnt = 4'd15;
    step(1'b1);
    i_valid = 1'b0;
    hi = 0;
    for (int k = 0; k < 15; k++) begin
      if (o_dat === 1'b1) hi++;
      step(1'b1);
    end
    n_cmp++; if (hi !== 15) begin n_err++; $display("FAIL max_high_ticks got=%0d want=15", hi); end
    n_cmp++; if (o_dat !== 1'b0) begin n_err++; $display("FAIL max_gap_dat got=%b want=0", o_dat); end
    n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL max_early_done got=%b want=0", o_done); end
    step(1'b1);
    n_cmp++; if (o_done !== 1'b1) begin n_err++; $display("FAIL max_done got=%b want=1", o_done); end
    n_cmp++; if (o_dat !== 1'b0) begin n_err++; $display("FAIL max_idle_dat got=%b want=0", o_dat); end
    step(1'b0);
  endtask

  // N=5 into the receiver model, i_en every other clock
  task automatic test_loopback;
    logic [7:0] mx;
    logic       seen;
    mx = 8'd0; seen = 1'b0;
    i_valid = 1'b1; i_cnt = 4'd5;
    step(1'b0);
    i_valid = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(k[0]);
      if (rx_cnt > mx) mx = rx_cnt;
      if (o_done === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL loop_done_timeout got=%b want=1", seen); end
    n_cmp++; if (mx !== 8'd5) begin n_err++; $display("FAIL loop_rx_max got=%0d want=5", mx); end
    n_cmp++; if (rx_cnt !== 8'd0) begin n_err++; $display("FAIL loop_rx_clear got=%0d want=0", rx_cnt); end
    step(1'b0);
  endtask

  // Async reset mid-run, then a clean N=2 request
  task automatic test_abort;
    logic any_done;
    any_done = 1'b0;
    i_valid = 1'b1; i_cnt = 4'd6;
    step(1'b0);
    i_valid = 1'b0;
    step(1'b1);
    step(1'b1);
    n_cmp++; if (o_dat !== 1'b1) begin n_err++; $display("FAIL abort_pre_dat got=%b want=1", o_dat); end
    i_rst = 1'b1;
    #2;
    n_cmp++; if (o_dat !== 1'b0) begin n_err++; $display("FAIL abort_dat_now got=%b want=0", o_dat); end
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready got=%b want=1", o_ready); end
    step(1'b1);
    i_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1);
      if (o_done === 1'b1) any_done = 1'b1;
    end
    n_cmp++; if (any_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done got=%b want=0", any_done); end
    i_valid = 1'b1; i_cnt = 4'd2;
    step(1'b0);
    i_valid = 1'b0;
    n_cmp++; if (o_dat !== 1'b1) begin n_err++; $display("FAIL abort_new_dat0 got=%b want=1", o_dat); end
    step(1'b1);
    n_cmp++; if (o_dat !== 1'b1) begin n_err++; $display("FAIL abort_new_dat1 got=%b want=1", o_dat); end
    step(1'b1);
    n_cmp++; if (o_dat !== 1'b0) begin n_err++; $display("FAIL abort_new_gap got=%b want=0", o_dat); end
    step(1'b1);
    n_cmp++; if (o_done !== 1'b1) begin n_err++; $display("FAIL abort_new_done got=%b want=1", o_done); end
    step(1'b0);
  endtask

  // Synchronous clear mid-run takes effect on the next edge
  task automatic test_sclr;
    i_valid = 1'b1; i_cnt = 4'd4;
    step(1'b0);
    i_valid = 1'b0;
    step(1'b1);
    i_sclr = 1'b1;
    #2;
    n_cmp++; if (o_dat !== 1'b1) begin n_err++; $display("FAIL sclr_before_edge got=%b want=1", o_dat); end
    step(1'b1);
    i_sclr = 1'b0;
    n_cmp++; if (o_dat !== 1'b0) begin n_err++; $display("FAIL sclr_dat got=%b want=0", o_dat); end
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL sclr_ready got=%b want=1", o_ready); end
    n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL sclr_done got=%b want=0", o_done); end
    step(1'b0);
  endtask

  // i_valid held: N=4 then N=2, second accepted on the o_done cycle
  task automatic test_back_to_back;
    logic [0:8] exp_dat;
    logic [0:8] exp_done;
    exp_dat  = 9'b111001100;
    exp_done = 9'b000010001;
    i_valid = 1'b1; i_cnt = 4'd4;
    step(1'b1);
    i_cnt = 4'd2;
    n_cmp++; if (o_dat !== 1'b1) begin n_err++; $display("FAIL b2b_first_dat got=%b want=1", o_dat); end
    for (int k = 0; k < 9; k++) begin
      step(1'b1);
      n_cmp++; if (o_dat !== exp_dat[k]) begin n_err++; $display("FAIL b2b_dat step=%0d got=%b want=%b", k, o_dat, exp_dat[k]); end
      n_cmp++; if (o_done !== exp_done[k]) begin n_err++; $display("FAIL b2b_done step=%0d got=%b want=%b", k, o_done, exp_done[k]); end
    end
    i_valid = 1'b0;
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got=%b want=1", o_ready); end
    step(1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_run3_slow();
    test_zero();
    test_max();
    test_loopback();
    test_abort();
    test_sclr();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
